alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator side of the ALU logical-unit interface: accepts one command (A, B, op) on a
//  valid/ready port, drives the combinational logical unit, waits a settle time, captures
//  result and computes the N/Z/C/V flags itself (the unit's flag outputs are ignored).
//  Presents the captured result on a valid/ready response port to the board/display logic.
//  One transaction in flight at a time.
// PARAMETERS
//  NBIT           8   operand/result width
//  SETTLE_CYCLES  1   cycles lu_* are held stable before capture (>=1)
// PORTS
//  clk         in   1     system clock, rising edge
//  rst         in   1     synchronous reset, active-high
//  cmd_valid   in   1     command valid
//  cmd_ready   out  1     sequencer can accept command
//  cmd_a       in   NBIT  operand A
//  cmd_b       in   NBIT  operand B / shift count
//  cmd_op      in   3     010 XOR, 011 shift left, 100 shift right; others unsupported
//  lu_a        out  NBIT  operand A to logical unit (registered)
//  lu_b        out  NBIT  operand B to logical unit (registered)
//  lu_op       out  3     operation to logical unit (registered)
//  lu_result   in   NBIT  logical-unit result (combinational from lu_*)
//  rsp_valid   out  1     response valid
//  rsp_ready   in   1     consumer accepts response
//  rsp_result  out  NBIT  captured result
//  rsp_n/z/c/v out  1     captured flags
//  rsp_err     out  1     1 = unsupported op
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1 from first cycle after reset release; lu_*, rsp_* all 0.
//  FSM: IDLE -(cmd_valid&cmd_ready)-> SETTLE -(cnt==SETTLE_CYCLES-1)-> HOLD -(rsp_ready)-> IDLE.
//  - IDLE: cmd_ready=1; on handshake at edge T, lu_a/b/op <= cmd_*, shamt/A/op latched.
//  - SETTLE: cmd_ready=0; counter 0..SETTLE_CYCLES-1; lu_* stable; on last cycle capture
//    lu_result and flags into rsp_*, rsp_valid<=1.
//  - HOLD: rsp_* stable while rsp_valid & !rsp_ready; on rsp_ready: rsp_valid<=0, -> IDLE.
//  Latency: handshake at edge T -> rsp_valid high after edge T+SETTLE_CYCLES (2 cycles @1).
//  Throughput: one command per SETTLE_CYCLES+2 cycles with rsp_ready tied high.
//  lu_* keep last command values after completion (not cleared except by rst).
//  Flags (from captured result R, latched A, s = latched B as unsigned):
//  - N = R[NBIT-1]; Z = (R==0); V = 0 always.
//  - XOR: C=0. SL: C = A[NBIT-s] if 1<=s<=NBIT else 0. SR: C = A[s-1] if 1<=s<=NBIT else 0.
//  - Unsupported op: rsp_result=0, N=Z=C=V=0, rsp_err=1; timing identical to valid ops.
//  cmd_valid while busy: ignored (cmd_ready=0), command not consumed.
//  rst mid-transaction: in-flight command dropped, rsp_valid=0, IDLE next cycle; no stale rsp.
//  rst and cmd_valid same cycle: reset wins, command not accepted.
//  rsp_valid never drops without rsp_ready; rsp_* never change while rsp_valid & !rsp_ready.
// TESTING (NBIT=8, SETTLE_CYCLES=1, behavioural logical-unit model)
//  XOR A=0xF0 B=0xFF -> rsp_result=0x0F N=0 Z=0 C=0 V=0 err=0, rsp_valid 2 cycles after accept
//  SL A=0x81 B=1 -> result 0x02, C=1, N=0; SL A=0x81 B=8 -> result 0x00, Z=1, C=1
//  SR A=0x03 B=1 -> result 0x01, C=1; SR A=0x80 B=0 -> result 0x80, N=1, C=0
//  op=3'b111 A=0x55 B=0x01 -> result 0x00, err=1, all flags 0, same latency
//  rsp_ready low 5 cycles: rsp_* stable, cmd_ready=0, 2nd cmd_valid not accepted until after
//  rsp handshake; rst asserted during SETTLE -> rsp_valid stays 0, cmd_ready=1 after release

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command, logical-unit and response signals of the ALU op sequencer.
// The sequencer uses the master modport; the board/logical-unit side uses the slave modport.
interface alu_op_sequencer_if #(
  parameter int NBIT = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [NBIT-1:0] cmd_a;
  logic [NBIT-1:0] cmd_b;
  logic [2:0]      cmd_op;

  logic [NBIT-1:0] lu_a;
  logic [NBIT-1:0] lu_b;
  logic [2:0]      lu_op;
  logic [NBIT-1:0] lu_result;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [NBIT-1:0] rsp_result;
  logic            rsp_n;
  logic            rsp_z;
  logic            rsp_c;
  logic            rsp_v;
  logic            rsp_err;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, lu_result, rsp_ready,
    output cmd_ready, lu_a, lu_b, lu_op,
    output rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, lu_result, rsp_ready,
    input  cmd_ready, lu_a, lu_b, lu_op,
    input  rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives one command at a time into the combinational logical unit, waits for it to settle,
// then captures the result with self-computed N/Z/C/V flags and offers it on the response port.
module alu_op_sequencer #(
  parameter int NBIT          = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_op_sequencer_if.master   bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             settle_done;
  logic [NBIT-1:0]  res_next;
  logic             c_next;
  logic             err_next;

  // Reset also drops cmd_ready so a command offered during reset is never consumed.
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign settle_done   = (state == SETTLE) && (cnt == CNT_W'(SETTLE_CYCLES - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)        state_next = SETTLE;
      SETTLE:  if (settle_done)   state_next = HOLD;
      HOLD:    if (bus.rsp_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Result and carry selection from the settled logical unit; s is lu_b taken as unsigned.
  always_comb begin
    res_next = '0;
    c_next   = 1'b0;
    err_next = 1'b0;
    case (bus.lu_op)
      OP_XOR: res_next = bus.lu_result;
      OP_SHL: begin
        res_next = bus.lu_result;
        for (int i = 0; i < NBIT; i++)
          if (bus.lu_b == NBIT'(NBIT - i)) c_next = bus.lu_a[i];
      end
      OP_SHR: begin
        res_next = bus.lu_result;
        for (int i = 0; i < NBIT; i++)
          if (bus.lu_b == NBIT'(i + 1)) c_next = bus.lu_a[i];
      end
      default: err_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      bus.lu_a       <= '0;
      bus.lu_b       <= '0;
      bus.lu_op      <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_n      <= 1'b0;
      bus.rsp_z      <= 1'b0;
      bus.rsp_c      <= 1'b0;
      bus.rsp_v      <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        bus.lu_a  <= bus.cmd_a;
        bus.lu_b  <= bus.cmd_b;
        bus.lu_op <= bus.cmd_op;
        cnt       <= '0;
      end
      if ((state == SETTLE) && !settle_done) cnt <= cnt + CNT_W'(1);
      if (settle_done) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_result <= res_next;
        bus.rsp_n      <= res_next[NBIT-1];
        bus.rsp_z      <= !err_next && (res_next == '0);
        bus.rsp_c      <= c_next;
        bus.rsp_v      <= 1'b0;
        bus.rsp_err    <= err_next;
      end
      if ((state == HOLD) && bus.rsp_ready) bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer against a plain-arithmetic reference model,
// with a behavioural logical unit closing the lu_* loop.
module tb_alu_op_sequencer;
  localparam int NBIT   = 8;
  localparam int SETTLE = 1;

  typedef struct packed {
    logic [7:0] res;
    logic       n;
    logic       z;
    logic       c;
    logic       v;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.NBIT(NBIT)) bus ();

  alu_op_sequencer #(.NBIT(NBIT), .SETTLE_CYCLES(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural logical unit; garbage on unsupported ops so the sequencer must zero it.
  assign bus.lu_result = (bus.lu_op == 3'b010) ? (bus.lu_a ^ bus.lu_b) :
                         (bus.lu_op == 3'b011) ? (bus.lu_a << bus.lu_b) :
                         (bus.lu_op == 3'b100) ? (bus.lu_a >> bus.lu_b) :
                                                 (bus.lu_a ^ 8'hA5);

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Shifts done in a double-width word; the carry is the bit that leaves the operand window.
  function automatic rsp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    rsp_t        r;
    logic [15:0] w;
    r = '0;
    case (op)
      3'b010: r.res = a ^ b;
      3'b011: begin
        w     = {8'h00, a} << b;
        r.res = w[7:0];
        r.c   = w[8];
      end
      3'b100: begin
        w     = {a, 8'h00} >> b;
        r.res = w[15:8];
        r.c   = w[7];
      end
      default: r.err = 1'b1;
    endcase
    r.n = !r.err && r.res[7];
    r.z = !r.err && (r.res == 8'h00);
    return r;
  endfunction

  function automatic rsp_t observed();
    return {bus.rsp_result, bus.rsp_n, bus.rsp_z, bus.rsp_c, bus.rsp_v, bus.rsp_err};
  endfunction

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input int hold);
    rsp_t exp;
    rsp_t got;
    int   lat;
    exp = model(a, b, op);
    @(negedge clk);
    check("ready_pre", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("ready_busy", bus.cmd_ready, 1'b0);
    check("valid_early", bus.rsp_valid, 1'b0);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, SETTLE);
    got = observed();
    check($sformatf("res a=%h b=%h op=%0d", a, b, op), got.res, exp.res);
    check("flag_n", got.n, exp.n);
    check("flag_z", got.z, exp.z);
    check("flag_c", got.c, exp.c);
    check("flag_v", got.v, exp.v);
    check("err", got.err, exp.err);
    // Stall the consumer while offering a competing command that must be ignored.
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = ~a;
      bus.cmd_b     = b + 8'd1;
      bus.cmd_op    = 3'b010;
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1'b1);
      check("hold_stable", observed(), exp);
      check("hold_ready", bus.cmd_ready, 1'b0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("valid_drop", bus.rsp_valid, 1'b0);
    check("ready_post", bus.cmd_ready, 1'b1);
    check("lu_a_kept", bus.lu_a, a);
    check("lu_op_kept", bus.lu_op, op);
  endtask

  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 8'h33;
    bus.cmd_b     = 8'h01;
    bus.cmd_op    = 3'b010;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_in_rst", bus.cmd_ready, 1'b0);
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1'b1);
    check("rst_valid", bus.rsp_valid, 1'b0);
    check("rst_lu", {bus.lu_a, bus.lu_b, 5'(bus.lu_op)}, 21'h0);
    check("rst_rsp", observed(), '0);

    run_txn(8'hF0, 8'hFF, 3'b010, 0);
    run_txn(8'h81, 8'h01, 3'b011, 1);
    run_txn(8'h81, 8'h08, 3'b011, 0);
    run_txn(8'h03, 8'h01, 3'b100, 2);
    run_txn(8'h80, 8'h00, 3'b100, 0);
    run_txn(8'h55, 8'h01, 3'b111, 5);
    run_txn(8'hC3, 8'h09, 3'b011, 0);
    run_txn(8'hC3, 8'h08, 3'b100, 0);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [2:0] rop;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0:       rop = 3'b010;
        1:       rop = 3'b011;
        2:       rop = 3'b100;
        default: rop = 3'($urandom);
      endcase
      run_txn(ra, rb, rop, $urandom_range(0, 3));
    end

    // Reset while the command is settling: nothing may come out afterwards.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 8'h5A;
    bus.cmd_b     = 8'h0F;
    bus.cmd_op    = 3'b010;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    check("rst_mid_ready", bus.cmd_ready, 1'b1);
    check("rst_mid_valid2", bus.rsp_valid, 1'b0);
    @(negedge clk);
    check("rst_mid_valid3", bus.rsp_valid, 1'b0);

    // Reset and command in the same cycle: reset wins.
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 8'h77;
    rst           = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_cmd_lu_a", bus.lu_a, 8'h00);
    @(negedge clk);
    check("rst_cmd_valid", bus.rsp_valid, 1'b0);

    run_txn(8'h0F, 8'h04, 3'b011, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
